// File: rtl/phase_to_freq_pkg.sv
// Shared types and constants for the phase-word to frequency converter.
package phase_to_freq_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [31:0] CLK_125M   = 32'd125_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

endpackage

// File: rtl/phase_to_freq_shift_add_core.sv
// Right-shifting shift-add multiplier datapath: one multiplier bit per step.
module shift_add_core
    import phase_to_freq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand_in,
    input  logic [DATA_W-1:0] mplier_in,
    output logic [DATA_W-1:0] prod_hi,
    output logic              prod_lo_msb,
    output logic              last
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     sum;

    // Multiplier lives in the low half of acc; its LSB selects the add, and
    // product bits shift in from the top as multiplier bits shift out.
    always_comb begin
        addend = acc[0] ? mcand : '0;
        sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, addend};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            mcand <= mcand_in;
            acc   <= {{DATA_W{1'b0}}, mplier_in};
            count <= CNT_W'(DATA_W);
        end else if (step && (count != '0)) begin
            acc   <= {sum, acc[DATA_W-1:1]};
            count <= count - CNT_W'(1);
        end
    end

    assign prod_hi     = acc[2*DATA_W-1:DATA_W];
    assign prod_lo_msb = acc[DATA_W-1];
    assign last        = (count == CNT_W'(1));

endmodule

// File: rtl/phase_to_freq.sv
// Converts an NCO phase increment to Hz: freq = round(phase_word * clk_freq / 2^DATA_W).
module phase_to_freq
    import phase_to_freq_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter bit          ROUND_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] phase_word,
    input  logic [DATA_W-1:0] clk_freq,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] freq
);

    state_t            state, state_nxt;
    logic              load, step, last, lo_msb;
    logic [DATA_W-1:0] hi, rnd_add;

    shift_add_core #(.DATA_W(DATA_W)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .step       (step),
        .mcand_in   (clk_freq),
        .mplier_in  (phase_word),
        .prod_hi    (hi),
        .prod_lo_msb(lo_msb),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) state_nxt = ST_ROUND;
            end
            ST_ROUND: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign ready = (state == ST_IDLE);

    // Product never exceeds (2^W-1)^2, so adding the round bit cannot wrap.
    always_comb begin
        rnd_add = '0;
        if (ROUND_EN) rnd_add = DATA_W'(lo_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            freq  <= '0;
        end else begin
            valid <= 1'b0;
            if (state == ST_ROUND) begin
                freq  <= hi + rnd_add;
                valid <= 1'b1;
            end
        end
    end

endmodule
